// File: rtl/udp_rx_payload_packer_if.sv
// Frame output bus of the UDP receive payload packer.
// master: the packer (drives the frame), slave: the consuming user logic.
interface udp_rx_payload_packer_if #(
   parameter int MAX_BYTES = 120,
   parameter int CNT_W     = 16
) ();

   logic                   rx_data_valid;
   logic                   rx_data_ready;
   logic [MAX_BYTES*8-1:0] rx_data;
   logic [CNT_W-1:0]       rx_data_length;
   logic                   rx_trunc;
   logic                   rx_len_err;

   modport master (
      output rx_data_valid,
      output rx_data,
      output rx_data_length,
      output rx_trunc,
      output rx_len_err,
      input  rx_data_ready
   );

   modport slave (
      input  rx_data_valid,
      input  rx_data,
      input  rx_data_length,
      input  rx_trunc,
      input  rx_len_err,
      output rx_data_ready
   );

endinterface

// File: rtl/udp_rx_payload_packer.sv
// UDP receive payload packer.
// Collects the byte burst from udp_ip_mac_top into one wide left-justified
// word (first byte in the top byte lane) and hands it to the user logic with
// a valid/ready handshake, the stored length, and truncation/length flags.
// Frames that finish while the output is still occupied are counted and lost.
module udp_rx_payload_packer #(
   parameter int MAX_BYTES = 120,
   parameter int CNT_W     = 16
) (
   input  logic                           rgmii_clk,
   input  logic                           rstn,
   input  logic                           udp_rec_data_valid,
   input  logic [7:0]                     udp_rec_rdata,
   input  logic [CNT_W-1:0]               udp_rec_data_length,
   udp_rx_payload_packer_if.master        rx_if,
   output logic [CNT_W-1:0]               rx_drop_cnt
);

   localparam int W     = MAX_BYTES * 8;
   localparam int IDX_W = $clog2(W);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RECV = 1'b1;

   logic [0:0]       state;
   logic             valid_d;
   logic [W-1:0]     asm_buf;
   logic [CNT_W-1:0] byte_cnt;
   logic [CNT_W-1:0] exp_len;
   logic             trunc_pend;

   logic             slot_ok;
   logic [IDX_W-1:0] slot_lsb;
   logic             start;
   logic             commit;
   logic             out_free;

   // Byte lane for the next incoming byte; only meaningful while slots remain
   always_comb begin
      slot_ok  = (byte_cnt < MAX_CNT);
      slot_lsb = '0;
      if (slot_ok) begin
         slot_lsb = IDX_W'((MAX_BYTES - 1 - int'(byte_cnt)) * 8);
      end
   end

   // Frame start needs a rising edge of the strobe; frame end is its fall
   always_comb begin
      start    = (state == IDLE) && udp_rec_data_valid && !valid_d;
      commit   = (state == RECV) && !udp_rec_data_valid;
      out_free = !rx_if.rx_data_valid || rx_if.rx_data_ready;
   end

   // Receive FSM and assembly buffer
   // valid_d resets high so a burst already running at reset release is skipped
   always_ff @(posedge rgmii_clk) begin
      if (!rstn) begin
         state      <= IDLE;
         valid_d    <= 1'b1;
         asm_buf    <= '0;
         byte_cnt   <= '0;
         exp_len    <= '0;
         trunc_pend <= 1'b0;
      end else begin
         valid_d <= udp_rec_data_valid;
         case (state)
            IDLE: begin
               if (start) begin
                  asm_buf    <= {udp_rec_rdata, {(W-8){1'b0}}};
                  byte_cnt   <= ONE_CNT;
                  exp_len    <= udp_rec_data_length;
                  trunc_pend <= 1'b0;
                  state      <= RECV;
               end
            end
            RECV: begin
               if (udp_rec_data_valid) begin
                  if (slot_ok) begin
                     asm_buf[slot_lsb +: 8] <= udp_rec_rdata;
                  end else begin
                     trunc_pend <= 1'b1;
                  end
                  if (byte_cnt != '1) begin
                     byte_cnt <= byte_cnt + ONE_CNT;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output register: load on commit when free, else count the drop; handshake clears valid
   always_ff @(posedge rgmii_clk) begin
      if (!rstn) begin
         rx_if.rx_data_valid  <= 1'b0;
         rx_if.rx_data        <= '0;
         rx_if.rx_data_length <= '0;
         rx_if.rx_trunc       <= 1'b0;
         rx_if.rx_len_err     <= 1'b0;
         rx_drop_cnt          <= '0;
      end else if (commit && out_free) begin
         rx_if.rx_data_valid  <= 1'b1;
         rx_if.rx_data        <= asm_buf;
         rx_if.rx_data_length <= slot_ok ? byte_cnt : MAX_CNT;
         rx_if.rx_trunc       <= trunc_pend;
         rx_if.rx_len_err     <= (byte_cnt != exp_len);
      end else begin
         if (commit && (rx_drop_cnt != '1)) begin
            rx_drop_cnt <= rx_drop_cnt + ONE_CNT;
         end
         if (rx_if.rx_data_valid && rx_if.rx_data_ready) begin
            rx_if.rx_data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_udp_rx_payload_packer.sv
// Testbench for udp_rx_payload_packer: directed scenarios with literal
// expectations plus randomized bursts against a frame-level reference model.
module tb_udp_rx_payload_packer;

   localparam int MAX_BYTES = 120;
   localparam int CNT_W     = 16;
   localparam int W         = MAX_BYTES * 8;

   logic             rgmii_clk = 1'b0;
   logic             rstn = 1'b0;
   logic             udp_rec_data_valid = 1'b0;
   logic [7:0]       udp_rec_rdata = 8'h00;
   logic [CNT_W-1:0] udp_rec_data_length = '0;
   logic [CNT_W-1:0] rx_drop_cnt;

   udp_rx_payload_packer_if #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) rx_if ();

   udp_rx_payload_packer #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
      .rgmii_clk           (rgmii_clk),
      .rstn                (rstn),
      .udp_rec_data_valid  (udp_rec_data_valid),
      .udp_rec_rdata       (udp_rec_rdata),
      .udp_rec_data_length (udp_rec_data_length),
      .rx_if               (rx_if),
      .rx_drop_cnt         (rx_drop_cnt)
   );

   always #5 rgmii_clk = ~rgmii_clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit rand_ready = 1'b0;

   // ---------------- reference model (frame level) ----------------
   bit         m_started  = 1'b0;
   bit         m_prev_v   = 1'b1;
   bit         m_in_frame = 1'b0;
   int         m_cnt      = 0;
   int         m_exp_len  = 0;
   logic [7:0] m_cur [MAX_BYTES];
   logic [7:0] m_out [MAX_BYTES];
   bit         m_valid    = 1'b0;
   bit         m_trunc    = 1'b0;
   bit         m_lenerr   = 1'b0;
   int         m_len      = 0;
   int         m_drop     = 0;
   bit         m_free;
   bit         m_commit;

   // Frame boundaries come from strobe edges; a finished frame goes to the
   // output slot if it is empty or being taken this cycle, otherwise it is lost.
   always @(posedge rgmii_clk) begin
      if (!rstn) begin
         m_started  = 1'b1;
         m_prev_v   = 1'b1;
         m_in_frame = 1'b0;
         m_cnt      = 0;
         m_valid    = 1'b0;
         m_trunc    = 1'b0;
         m_lenerr   = 1'b0;
         m_len      = 0;
         m_drop     = 0;
         for (int i = 0; i < MAX_BYTES; i++) m_out[i] = 8'h00;
      end else begin
         m_commit = m_in_frame && !udp_rec_data_valid;
         m_free   = !m_valid || rx_if.rx_data_ready;
         if (m_commit) begin
            if (m_free) begin
               for (int i = 0; i < MAX_BYTES; i++) m_out[i] = (i < m_cnt) ? m_cur[i] : 8'h00;
               m_len    = (m_cnt < MAX_BYTES) ? m_cnt : MAX_BYTES;
               m_trunc  = (m_cnt > MAX_BYTES);
               m_lenerr = (m_cnt != m_exp_len);
               m_valid  = 1'b1;
            end else if (m_drop < 65535) begin
               m_drop = m_drop + 1;
            end
            m_in_frame = 1'b0;
         end else if (m_valid && rx_if.rx_data_ready) begin
            m_valid = 1'b0;
         end
         if (m_in_frame && udp_rec_data_valid) begin
            if (m_cnt < MAX_BYTES) m_cur[m_cnt] = udp_rec_rdata;
            m_cnt = m_cnt + 1;
         end else if (!m_in_frame && udp_rec_data_valid && !m_prev_v) begin
            m_in_frame = 1'b1;
            m_cur[0]   = udp_rec_rdata;
            m_cnt      = 1;
            m_exp_len  = int'(udp_rec_data_length);
         end
         m_prev_v = udp_rec_data_valid;
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_data(input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         for (int j = 0; j < MAX_BYTES; j++) begin
            if (act[W-1-8*j -: 8] !== exp[W-1-8*j -: 8]) begin
               $display("FAIL rx_data byte %0d: got %02h expected %02h at %0t",
                        j, act[W-1-8*j -: 8], exp[W-1-8*j -: 8], $time);
               break;
            end
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge rgmii_clk);
      #1;
      if (rand_ready) rx_if.rx_data_ready = ($urandom_range(0, 3) != 0);
   endtask

   // mode 0: bytes 0,1,2..  mode 1: random  mode 2: 11,22,33..
   task automatic send_frame(input int n, input int len, input int mode);
      for (int i = 0; i < n; i++) begin
         udp_rec_data_valid  = 1'b1;
         udp_rec_rdata       = (mode == 0) ? 8'(i) : (mode == 2) ? 8'(8'h11 * (i + 1)) : 8'($urandom);
         udp_rec_data_length = CNT_W'(len);
         tick();
      end
      udp_rec_data_valid  = 1'b0;
      udp_rec_rdata       = 8'($urandom);
      udp_rec_data_length = CNT_W'($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rx_if.rx_data_ready = 1'b1;
      fork
         // every-cycle comparison against the model
         begin
            logic [W-1:0] ew;
            forever begin
               @(negedge rgmii_clk);
               if (m_started) begin
                  for (int i = 0; i < MAX_BYTES; i++) ew[W-1-8*i -: 8] = m_out[i];
                  chk("m_valid",   32'(rx_if.rx_data_valid),  32'(m_valid));
                  chk("m_length",  32'(rx_if.rx_data_length), 32'(m_len));
                  chk("m_trunc",   32'(rx_if.rx_trunc),       32'(m_trunc));
                  chk("m_len_err", 32'(rx_if.rx_len_err),     32'(m_lenerr));
                  chk("m_drop",    32'(rx_drop_cnt),          32'(m_drop));
                  chk_data(rx_if.rx_data, ew);
               end
            end
         end
         // directed scenarios, then random traffic
         begin
            rstn = 1'b0;
            tick();
            tick();
            @(negedge rgmii_clk);
            chk("rst_valid", 32'(rx_if.rx_data_valid), 32'd0);
            chk("rst_len",   32'(rx_if.rx_data_length), 32'd0);
            chk("rst_drop",  32'(rx_drop_cnt), 32'd0);
            rstn = 1'b1;
            tick();
            tick();

            // 1) short frame, latency and single-cycle valid
            send_frame(4, 4, 2);
            @(negedge rgmii_clk);
            chk("t1_commit_cycle_valid", 32'(rx_if.rx_data_valid), 32'd0);
            @(negedge rgmii_clk);
            chk("t1_valid",   32'(rx_if.rx_data_valid), 32'd1);
            chk("t1_word",    rx_if.rx_data[W-1 -: 32], 32'h11223344);
            chk("t1_rest0",   32'(rx_if.rx_data[W-33:0] == '0), 32'd1);
            chk("t1_len",     32'(rx_if.rx_data_length), 32'd4);
            chk("t1_len_err", 32'(rx_if.rx_len_err), 32'd0);
            chk("t1_trunc",   32'(rx_if.rx_trunc), 32'd0);
            @(negedge rgmii_clk);
            chk("t1_valid_drop", 32'(rx_if.rx_data_valid), 32'd0);

            // 2) oversize frame truncated to capacity
            tick();
            send_frame(130, 130, 0);
            @(negedge rgmii_clk);
            @(negedge rgmii_clk);
            chk("t2_valid",   32'(rx_if.rx_data_valid), 32'd1);
            chk("t2_len",     32'(rx_if.rx_data_length), 32'd120);
            chk("t2_last",    32'(rx_if.rx_data[7:0]), 32'd119);
            chk("t2_first",   32'(rx_if.rx_data[W-1 -: 8]), 32'd0);
            chk("t2_trunc",   32'(rx_if.rx_trunc), 32'd1);
            chk("t2_len_err", 32'(rx_if.rx_len_err), 32'd0);

            // 3) header length disagrees with burst length
            tick();
            send_frame(8, 10, 1);
            @(negedge rgmii_clk);
            @(negedge rgmii_clk);
            chk("t3_len_err", 32'(rx_if.rx_len_err), 32'd1);
            chk("t3_len",     32'(rx_if.rx_data_length), 32'd8);
            chk("t3_trunc",   32'(rx_if.rx_trunc), 32'd0);

            // 4) consumer stalled: first frame held, next two dropped
            tick();
            tick();
            rx_if.rx_data_ready = 1'b0;
            send_frame(2, 2, 2);
            tick();
            tick();
            send_frame(2, 2, 1);
            tick();
            tick();
            send_frame(2, 2, 1);
            tick();
            tick();
            @(negedge rgmii_clk);
            chk("t4_valid", 32'(rx_if.rx_data_valid), 32'd1);
            chk("t4_held",  32'(rx_if.rx_data[W-1 -: 16]), 32'h1122);
            chk("t4_len",   32'(rx_if.rx_data_length), 32'd2);
            chk("t4_drop",  32'(rx_drop_cnt), 32'd2);
            rx_if.rx_data_ready = 1'b1;
            tick();
            @(negedge rgmii_clk);
            chk("t4_accept_valid", 32'(rx_if.rx_data_valid), 32'd0);
            chk("t4_not_cleared",  32'(rx_if.rx_data[W-1 -: 16]), 32'h1122);

            // 5) accept and new commit in the same cycle
            rx_if.rx_data_ready = 1'b0;
            send_frame(3, 3, 2);
            tick();
            send_frame(4, 4, 0);
            rx_if.rx_data_ready = 1'b1;
            tick();
            rx_if.rx_data_ready = 1'b0;
            @(negedge rgmii_clk);
            chk("t5_valid", 32'(rx_if.rx_data_valid), 32'd1);
            chk("t5_word",  rx_if.rx_data[W-1 -: 32], 32'h00010203);
            chk("t5_len",   32'(rx_if.rx_data_length), 32'd4);
            chk("t5_drop",  32'(rx_drop_cnt), 32'd2);
            rx_if.rx_data_ready = 1'b1;
            tick();
            @(negedge rgmii_clk);
            chk("t5_accept_valid", 32'(rx_if.rx_data_valid), 32'd0);

            // 6) reset in the middle of a 50-byte burst
            tick();
            tick();
            for (int i = 0; i < 50; i++) begin
               udp_rec_data_valid  = 1'b1;
               udp_rec_rdata       = 8'(i + 100);
               udp_rec_data_length = CNT_W'(50);
               if (i == 20) rstn = 1'b0;
               if (i == 24) rstn = 1'b1;
               tick();
               if (i == 22) begin
                  @(negedge rgmii_clk);
                  chk("t6_rst_valid", 32'(rx_if.rx_data_valid), 32'd0);
                  chk("t6_rst_len",   32'(rx_if.rx_data_length), 32'd0);
                  chk("t6_rst_drop",  32'(rx_drop_cnt), 32'd0);
                  chk("t6_rst_data",  32'(rx_if.rx_data == '0), 32'd1);
               end
            end
            udp_rec_data_valid = 1'b0;
            tick();
            tick();
            @(negedge rgmii_clk);
            chk("t6_tail_ignored", 32'(rx_if.rx_data_valid), 32'd0);
            send_frame(5, 5, 1);
            @(negedge rgmii_clk);
            @(negedge rgmii_clk);
            chk("t6_next_valid",   32'(rx_if.rx_data_valid), 32'd1);
            chk("t6_next_len",     32'(rx_if.rx_data_length), 32'd5);
            chk("t6_next_len_err", 32'(rx_if.rx_len_err), 32'd0);

            // randomized bursts, gaps and consumer back-pressure
            rand_ready = 1'b1;
            repeat (40) begin
               int n;
               int len;
               n   = $urandom_range(1, 140);
               len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 140) : n;
               send_frame(n, len, 1);
               repeat ($urandom_range(1, 3)) tick();
            end
            rand_ready = 1'b0;
            rx_if.rx_data_ready = 1'b1;
            repeat (5) tick();
         end
      join_any
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
